board_renderer: RTL and testbench
=================================

// Module: board_renderer
// PURPOSE
//  Parametrised, pipelined successor of the battleship pixel generator. Maps a VGA
//  pixel (x_i,y_i) to RGB for two side-by-side NxN boards (player | divider | PC).
//  Board state is snapshotted once per frame, so there is no mid-frame tearing.
//  Adds a blinking cursor, H/V placement preview with conflict colouring, and PC-ship hiding.
//  Sits between the VGA timing generator and the DAC/output registers.
// PARAMETERS
//  BOARD_SIZE   5   cells per side (N), 2..8
//  CELL_PX      58  cell pitch minus frame, pixels
//  FRAME_PX     4   frame thickness at top/left of each pitch, pixels
//  LINE_PX      2   divider width between boards, pixels
//  COORD_W      10  width of x_i/y_i
//  BLINK_FRAMES 30  frames per cursor blink half-period, >=1
// PORTS
//  clk            in   1        pixel clock
//  rst_n          in   1        asynchronous active-low reset
//  pix_valid_i    in   1        x_i/y_i are inside the visible area
//  x_i, y_i       in   COORD_W  pixel coordinate
//  frame_start_i  in   1        1-cycle pulse at start of vertical blank
//  player_board_i in   2*N*N    cell state, flattened; cell (r,c) at bits [2*(r*N+c)+:2]
//  pc_board_i     in   2*N*N    same encoding, PC board
//  cursor_row_i   in   3        cursor row (player board)
//  cursor_col_i   in   3        cursor column (player board)
//  place_active_i in   1        placement preview on
//  place_len_i    in   3        ship length for preview, 0..N
//  place_vert_i   in   1        0: preview extends right; 1: preview extends down
//  reveal_pc_i    in   1        1: show PC ships; 0: draw PC BARCO as AGUA
//  pix_valid_o    out  1        pix_valid_i delayed 2 cycles
//  r_o, g_o, b_o  out  8 each   pixel colour
// BEHAVIOUR
//  - Reset: pix_valid_o=0, r/g/b_o=0, snapshots all AGUA, blink_cnt=0, blink_on=1.
//  - Pitch P=CELL_PX+FRAME_PX. Player board at x in [0,N*P). Divider at [N*P,N*P+LINE_PX).
//    PC board at [N*P+LINE_PX, 2*N*P+LINE_PX). All boards use y in [0,N*P).
//  - Inside a pitch, offset <FRAME_PX on x or y is frame (white); otherwise it is cell interior.
//  - Latency is exactly 2 cycles; pipeline accepts one pixel every cycle.
//    S1 registers region, row, col and interior flag. S2 registers colour.
//  - When pix_valid_i=0, the pixel emerges 2 cycles later with valid=0 and rgb=0.
//  - Snapshot: in the cycle frame_start_i=1, both board inputs and the cursor/placement
//    inputs are latched. Rendering uses only latched values. reveal_pc_i is live.
//  - Blink: on each frame_start_i, blink_cnt increments. At BLINK_FRAMES-1 it wraps to 0
//    and blink_on toggles.
//  - Colour priority, highest first:
//    divider black > outside white > frame white > preview > cursor > cell state.
//  - Preview cells: row==cur_r and cur_c<=col<cur_c+len (H), or col==cur_c and
//    cur_r<=row<cur_r+len (V). Widths are extended so there is no overflow. Cells past N
//    are clipped, never wrapped. len=0 draws no preview.
//    Colour FF8C00; if the cell is BARCO, FF0000 (conflict).
//  - Cursor cell (player board, preview off): FFFFFF when blink_on, else its cell colour.
//  - Player: AGUA 0000FF, BARCO 00FF00, SELEC FF0000, CONF FFFF00.
//  - PC: AGUA 202020, BARCO 800080 (202020 if !reveal_pc_i), SELEC FFFF00, CONF FFA500.
//  - Cursor or len outside the board: only the in-range cells are drawn, no error.
//  - Reset mid-frame: outputs go to 0 immediately. Snapshot stays AGUA until the next
//    frame_start_i.
// CONFIGURATION
//  - CURSOR_BLINK_EN defined: blink counter present; behaviour as above.
//  - Not defined: no counter; blink_on is held at 1 and the cursor is always solid white.
//    frame_start_i still drives the snapshot.
// STRUCTURE
//  - board_pkg: cell_t enum (AGUA, BARCO, CASILLA_SELECCION, CASILLA_CONFIRMADA),
//    rgb_t struct, colour localparams, region_t enum (NONE, PLAYER, DIVIDER, PC).
//  - Sub-module board_cell_locator: combinational x/y -> region, row, col, interior.
//    It is instantiated in S1.
// TESTING (defaults: P=62, player x 0..309, divider 310..311, PC x 312..621)
//  1. Reset, snapshot player(0,0)=BARCO, pixel (5,5), preview off, cursor (4,4)
//     -> 2 cycles later valid=1, rgb=00FF00.
//  2. Pixel (2,2) -> FFFFFF (frame); pixel (310,100) -> 000000; pixel (700,10) -> FFFFFF.
//  3. PC(0,0)=BARCO, pixel (320,10): reveal=0 -> 202020; reveal=1 -> 800080.
//  4. Preview cursor (0,3), len=4, H -> cols 3,4 orange, col 0 not drawn.
//     Same with V -> rows 0..3 of col 3; a BARCO cell in the preview -> FF0000.
//  5. Change player_board_i mid-frame -> output unchanged until after the next
//     frame_start_i.
//  6. CURSOR_BLINK_EN, BLINK_FRAMES=2 -> cursor pixel alternates FFFFFF / cell colour
//     every 2 frame_start_i pulses. Without the macro -> always FFFFFF.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and colours for the two-board renderer.
//   cell_t   : 2-bit cell state as stored in the flattened board vectors
//   region_t : screen region a pixel falls into
//   rgb_t    : packed 24-bit colour {r, g, b}
// Colour helpers map a cell state to its on-screen colour for each board.
package board_pkg;

   typedef enum logic [1:0] {
      AGUA               = 2'd0,
      BARCO              = 2'd1,
      CASILLA_SELECCION  = 2'd2,
      CASILLA_CONFIRMADA = 2'd3
   } cell_t;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      PLAYER  = 2'd1,
      DIVIDER = 2'd2,
      PC      = 2'd3
   } region_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t COL_BLACK    = 24'h000000;
   localparam rgb_t COL_WHITE    = 24'hFFFFFF;
   localparam rgb_t COL_PREVIEW  = 24'hFF8C00;
   localparam rgb_t COL_CONFLICT = 24'hFF0000;

   localparam rgb_t COL_P_AGUA  = 24'h0000FF;
   localparam rgb_t COL_P_BARCO = 24'h00FF00;
   localparam rgb_t COL_P_SELEC = 24'hFF0000;
   localparam rgb_t COL_P_CONF  = 24'hFFFF00;

   localparam rgb_t COL_PC_AGUA  = 24'h202020;
   localparam rgb_t COL_PC_BARCO = 24'h800080;
   localparam rgb_t COL_PC_SELEC = 24'hFFFF00;
   localparam rgb_t COL_PC_CONF  = 24'hFFA500;

   function automatic rgb_t player_colour(input cell_t c);
      case (c)
         AGUA:              return COL_P_AGUA;
         BARCO:             return COL_P_BARCO;
         CASILLA_SELECCION: return COL_P_SELEC;
         default:           return COL_P_CONF;
      endcase
   endfunction

   // Hidden PC ships are indistinguishable from open water.
   function automatic rgb_t pc_colour(input cell_t c, input logic reveal);
      case (c)
         AGUA:              return COL_PC_AGUA;
         BARCO:             return reveal ? COL_PC_BARCO : COL_PC_AGUA;
         CASILLA_SELECCION: return COL_PC_SELEC;
         default:           return COL_PC_CONF;
      endcase
   endfunction

endpackage

// File: rtl/board_cell_locator.sv
// Combinational pixel locator: maps (x, y) to the screen region, the cell
// row/column inside that board and whether the pixel is cell interior
// (as opposed to the frame band at the top/left of each pitch).
// Ports:
//   x, y     in   COORD_W  pixel coordinate
//   region   out  2        region_t encoding (NONE, PLAYER, DIVIDER, PC)
//   row, col out  3        cell indices, valid when region is a board
//   interior out  1        1 when both offsets inside the pitch are >= FRAME_PX
module board_cell_locator
   import board_pkg::*;
#(
   parameter int BOARD_SIZE = 5,
   parameter int CELL_PX    = 58,
   parameter int FRAME_PX   = 4,
   parameter int LINE_PX    = 2,
   parameter int COORD_W    = 10
)(
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [1:0]         region,
   output logic [2:0]         row,
   output logic [2:0]         col,
   output logic               interior
);

   localparam int PITCH   = CELL_PX + FRAME_PX;
   localparam int BOARD_W = BOARD_SIZE * PITCH;
   localparam int PC_X0   = BOARD_W + LINE_PX;

   logic [31:0] xw, yw, x_local, x_off, y_off;
   logic [BOARD_SIZE-1:0] col_ge, row_ge;
   region_t region_c;
   logic [2:0] row_c, col_c;

   assign xw = 32'(x);
   assign yw = 32'(y);

   // The divider is drawn full height; the boards only cover y < BOARD_W.
   always_comb begin
      region_c = NONE;
      x_local  = '0;
      if (xw >= 32'(BOARD_W) && xw < 32'(PC_X0)) begin
         region_c = DIVIDER;
      end else if (yw < 32'(BOARD_W)) begin
         if (xw < 32'(BOARD_W)) begin
            region_c = PLAYER;
            x_local  = xw;
         end else if (xw >= 32'(PC_X0) && xw < 32'(PC_X0 + BOARD_W)) begin
            region_c = PC;
            x_local  = xw - 32'(PC_X0);
         end
      end
   end

   // Thermometer of pitch boundaries replaces a divide by PITCH.
   genvar gi;
   generate
      for (gi = 0; gi < BOARD_SIZE; gi++) begin : g_bound
         assign col_ge[gi] = (x_local >= 32'(gi * PITCH));
         assign row_ge[gi] = (yw >= 32'(gi * PITCH));
      end
   endgenerate

   always_comb begin
      row_c = '0;
      col_c = '0;
      for (int k = 1; k < BOARD_SIZE; k++) begin
         if (row_ge[k]) row_c = 3'(k);
         if (col_ge[k]) col_c = 3'(k);
      end
   end

   assign x_off    = x_local - (32'(col_c) * 32'(PITCH));
   assign y_off    = yw - (32'(row_c) * 32'(PITCH));
   assign interior = (x_off >= 32'(FRAME_PX)) && (y_off >= 32'(FRAME_PX));
   assign region   = region_c;
   assign row      = row_c;
   assign col      = col_c;

endmodule

// File: rtl/board_renderer.sv
// Two-board battleship pixel renderer (player | divider | PC), 2-cycle latency,
// one pixel per clock. Board, cursor and placement inputs are snapshotted on
// frame_start_i so a whole frame is drawn from one consistent state.
// Optional feature macro: CURSOR_BLINK_EN (blinking cursor; otherwise solid).
// Ports:
//   clk, rst_n                 pixel clock, asynchronous active-low reset
//   pix_valid_i, x_i, y_i      pixel request
//   frame_start_i              start of vertical blank, triggers snapshot/blink
//   player_board_i, pc_board_i flattened 2-bit cell states, cell (r,c) at 2*(r*N+c)
//   cursor_row_i/col_i         cursor on player board
//   place_active_i/len_i/vert_i placement preview controls
//   reveal_pc_i                show PC ships (live, not snapshotted)
//   pix_valid_o, r_o, g_o, b_o rendered pixel, 2 cycles after request
module board_renderer
   import board_pkg::*;
#(
   parameter int BOARD_SIZE   = 5,
   parameter int CELL_PX      = 58,
   parameter int FRAME_PX     = 4,
   parameter int LINE_PX      = 2,
   parameter int COORD_W      = 10,
   parameter int BLINK_FRAMES = 30
)(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                pix_valid_i,
   input  logic [COORD_W-1:0]                  x_i,
   input  logic [COORD_W-1:0]                  y_i,
   input  logic                                frame_start_i,
   input  logic [2*BOARD_SIZE*BOARD_SIZE-1:0]  player_board_i,
   input  logic [2*BOARD_SIZE*BOARD_SIZE-1:0]  pc_board_i,
   input  logic [2:0]                          cursor_row_i,
   input  logic [2:0]                          cursor_col_i,
   input  logic                                place_active_i,
   input  logic [2:0]                          place_len_i,
   input  logic                                place_vert_i,
   input  logic                                reveal_pc_i,
   output logic                                pix_valid_o,
   output logic [7:0]                          r_o,
   output logic [7:0]                          g_o,
   output logic [7:0]                          b_o
);

   localparam int CELLS      = BOARD_SIZE * BOARD_SIZE;
   localparam int BOARD_BITS = 2 * CELLS;
   localparam int SEL_W      = $clog2(BOARD_BITS);

   // ---------------- frame snapshot ----------------
   logic [BOARD_BITS-1:0] player_snap_reg, pc_snap_reg;
   logic [2:0]            cur_r_reg, cur_c_reg, len_reg;
   logic                  place_active_reg, place_vert_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         player_snap_reg  <= {CELLS{AGUA}};
         pc_snap_reg      <= {CELLS{AGUA}};
         cur_r_reg        <= '0;
         cur_c_reg        <= '0;
         len_reg          <= '0;
         place_active_reg <= 1'b0;
         place_vert_reg   <= 1'b0;
      end else if (frame_start_i) begin
         player_snap_reg  <= player_board_i;
         pc_snap_reg      <= pc_board_i;
         cur_r_reg        <= cursor_row_i;
         cur_c_reg        <= cursor_col_i;
         len_reg          <= place_len_i;
         place_active_reg <= place_active_i;
         place_vert_reg   <= place_vert_i;
      end
   end

   // ---------------- cursor blink ----------------
   logic blink_on;

`ifdef CURSOR_BLINK_EN
   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [CNT_W-1:0] blink_cnt_reg;
   logic             blink_on_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_reg <= '0;
         blink_on_reg  <= 1'b1;
      end else if (frame_start_i) begin
         if (blink_cnt_reg == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
      end
   end

   assign blink_on = blink_on_reg;
`else
   assign blink_on = 1'b1;
`endif

   // ---------------- stage 1: locate ----------------
   logic [1:0] loc_region;
   logic [2:0] loc_row, loc_col;
   logic       loc_interior;

   board_cell_locator #(
      .BOARD_SIZE (BOARD_SIZE),
      .CELL_PX    (CELL_PX),
      .FRAME_PX   (FRAME_PX),
      .LINE_PX    (LINE_PX),
      .COORD_W    (COORD_W)
   ) u_locator (
      .x        (x_i),
      .y        (y_i),
      .region   (loc_region),
      .row      (loc_row),
      .col      (loc_col),
      .interior (loc_interior)
   );

   logic       valid_s1_reg, interior_s1_reg;
   region_t    region_s1_reg;
   logic [2:0] row_s1_reg, col_s1_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_s1_reg    <= 1'b0;
         region_s1_reg   <= NONE;
         row_s1_reg      <= '0;
         col_s1_reg      <= '0;
         interior_s1_reg <= 1'b0;
      end else begin
         valid_s1_reg    <= pix_valid_i;
         region_s1_reg   <= region_t'(loc_region);
         row_s1_reg      <= loc_row;
         col_s1_reg      <= loc_col;
         interior_s1_reg <= loc_interior;
      end
   end

   // ---------------- stage 2: colour ----------------
   logic [SEL_W-1:0] cell_sel;
   cell_t            player_cell, pc_cell;
   logic [3:0]       row_e, col_e, cur_r_e, cur_c_e, len_e;
   logic             in_preview, is_cursor;
   rgb_t             colour_next;

   assign cell_sel    = SEL_W'(2 * (int'(row_s1_reg) * BOARD_SIZE + int'(col_s1_reg)));
   assign player_cell = cell_t'(player_snap_reg[cell_sel +: 2]);
   assign pc_cell     = cell_t'(pc_snap_reg[cell_sel +: 2]);

   // One extra bit so cursor+len never wraps; cells beyond the board never
   // reach this point, which clips the preview at the edge.
   assign row_e   = {1'b0, row_s1_reg};
   assign col_e   = {1'b0, col_s1_reg};
   assign cur_r_e = {1'b0, cur_r_reg};
   assign cur_c_e = {1'b0, cur_c_reg};
   assign len_e   = {1'b0, len_reg};

   always_comb begin
      in_preview = 1'b0;
      if (place_active_reg) begin
         if (place_vert_reg)
            in_preview = (col_s1_reg == cur_c_reg) && (row_e >= cur_r_e)
                         && (row_e < cur_r_e + len_e);
         else
            in_preview = (row_s1_reg == cur_r_reg) && (col_e >= cur_c_e)
                         && (col_e < cur_c_e + len_e);
      end
   end

   assign is_cursor = !place_active_reg && (row_s1_reg == cur_r_reg)
                      && (col_s1_reg == cur_c_reg);

   always_comb begin
      colour_next = COL_BLACK;
      if (valid_s1_reg) begin
         case (region_s1_reg)
            DIVIDER: colour_next = COL_BLACK;
            NONE:    colour_next = COL_WHITE;
            PLAYER: begin
               if (!interior_s1_reg)
                  colour_next = COL_WHITE;
               else if (in_preview)
                  colour_next = (player_cell == BARCO) ? COL_CONFLICT : COL_PREVIEW;
               else if (is_cursor && blink_on)
                  colour_next = COL_WHITE;
               else
                  colour_next = player_colour(player_cell);
            end
            default: begin
               if (!interior_s1_reg)
                  colour_next = COL_WHITE;
               else
                  colour_next = pc_colour(pc_cell, reveal_pc_i);
            end
         endcase
      end
   end

   logic valid_s2_reg;
   rgb_t rgb_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_s2_reg <= 1'b0;
         rgb_reg      <= COL_BLACK;
      end else begin
         valid_s2_reg <= valid_s1_reg;
         rgb_reg      <= colour_next;
      end
   end

   assign pix_valid_o = valid_s2_reg;
   assign r_o         = rgb_reg.r;
   assign g_o         = rgb_reg.g;
   assign b_o         = rgb_reg.b;

endmodule

// File: tb/tb_board_renderer.sv
// Directed testbench for board_renderer with default geometry
// (pitch 62: player x 0..309, divider 310..311, PC x 312..621).
module tb_board_renderer;

   localparam int N = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_valid_i, frame_start_i;
   logic [9:0]  x_i, y_i;
   logic [49:0] player_board_i, pc_board_i;
   logic [2:0]  cursor_row_i, cursor_col_i, place_len_i;
   logic        place_active_i, place_vert_i, reveal_pc_i;
   logic        pix_valid_o;
   logic [7:0]  r_o, g_o, b_o;

   int total = 0;
   int bad = 0;
   int n_pulses = 0;

   always #5 clk = ~clk;

   board_renderer #(
      .BOARD_SIZE(5), .CELL_PX(58), .FRAME_PX(4), .LINE_PX(2),
      .COORD_W(10), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_valid_i(pix_valid_i), .x_i(x_i), .y_i(y_i),
      .frame_start_i(frame_start_i), .player_board_i(player_board_i),
      .pc_board_i(pc_board_i), .cursor_row_i(cursor_row_i), .cursor_col_i(cursor_col_i),
      .place_active_i(place_active_i), .place_len_i(place_len_i),
      .place_vert_i(place_vert_i), .reveal_pc_i(reveal_pc_i),
      .pix_valid_o(pix_valid_o), .r_o(r_o), .g_o(g_o), .b_o(b_o)
   );

   function automatic logic [49:0] with_cell(input logic [49:0] b, input int r,
                                             input int c, input logic [1:0] v);
      logic [49:0] t;
      t = b;
      t[2*(r*N+c) +: 2] = v;
      return t;
   endfunction

   // Present one pixel and return what emerges two clocks later.
   task automatic drive_px(input int x, input int y, input logic v,
                           output logic [23:0] rgb, output logic vo);
      x_i = 10'(x);
      y_i = 10'(y);
      pix_valid_i = v;
      @(posedge clk);
      @(posedge clk);
      #1;
      rgb = {r_o, g_o, b_o};
      vo  = pix_valid_o;
      pix_valid_i = 1'b0;
      $display("pixel x=%0d y=%0d v=%0b -> v=%0b rgb=%06h", x, y, v, vo, rgb);
   endtask

   task automatic frame_pulse();
      frame_start_i = 1'b1;
      @(posedge clk);
      #1;
      frame_start_i = 1'b0;
      n_pulses++;
   endtask

   task automatic test_reset();
      logic [23:0] rgb;
      logic vo;
      rst_n = 1'b0;
      pix_valid_i = 1'b1;
      x_i = 10'd100;
      y_i = 10'd100;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (pix_valid_o !== 1'b0 || {r_o, g_o, b_o} !== 24'h0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%0b rgb=%06h, want v=0 rgb=000000",
                  pix_valid_o, {r_o, g_o, b_o});
      end
      player_board_i = '1;   // not yet snapshotted: must not appear
      rst_n = 1'b1;
      n_pulses = 0;
      drive_px(100, 100, 1'b1, rgb, vo);
      total++;
      if (vo !== 1'b1 || rgb !== 24'h0000FF) begin
         bad++;
         $display("FAIL reset_snapshot_agua: got v=%0b rgb=%06h, want v=1 rgb=0000ff", vo, rgb);
      end
      player_board_i = '0;
   endtask

   task automatic test_basic();
      logic [23:0] rgb;
      logic vo;
      int qx[$], qy[$];
      logic [23:0] qe[$];
      logic [49:0] b;
      b = '0;
      b = with_cell(b, 0, 0, 2'b01);
      b = with_cell(b, 1, 0, 2'b10);
      b = with_cell(b, 1, 1, 2'b11);
      player_board_i = b;
      cursor_row_i = 3'd4;
      cursor_col_i = 3'd4;
      place_active_i = 1'b0;
      frame_pulse();
      qx = '{5, 10, 72, 134};
      qy = '{5, 72, 72, 134};
      qe = '{24'h00FF00, 24'hFF0000, 24'hFFFF00, 24'h0000FF};
      for (int i = 0; i < qx.size(); i++) begin
         drive_px(qx[i], qy[i], 1'b1, rgb, vo);
         total++;
         if (vo !== 1'b1 || rgb !== qe[i]) begin
            bad++;
            $display("FAIL basic[%0d]: got v=%0b rgb=%06h, want v=1 rgb=%06h", i, vo, rgb, qe[i]);
         end
      end
      drive_px(2, 2, 1'b0, rgb, vo);
      total++;
      if (vo !== 1'b0 || rgb !== 24'h0) begin
         bad++;
         $display("FAIL invalid_pixel: got v=%0b rgb=%06h, want v=0 rgb=000000", vo, rgb);
      end
   endtask

   task automatic test_regions();
      logic [23:0] rgb;
      logic vo;
      int qx[$], qy[$];
      logic [23:0] qe[$];
      // last entry is the cursor cell (4,4); blink is still on after one pulse
      qx = '{2, 310, 311, 700, 309, 62, 5, 312, 621, 622, 260};
      qy = '{2, 100, 100, 10, 5, 10, 310, 10, 5, 5, 260};
      qe = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h0000FF, 24'hFFFFFF,
             24'hFFFFFF, 24'hFFFFFF, 24'h202020, 24'hFFFFFF, 24'hFFFFFF};
      for (int i = 0; i < qx.size(); i++) begin
         drive_px(qx[i], qy[i], 1'b1, rgb, vo);
         total++;
         if (vo !== 1'b1 || rgb !== qe[i]) begin
            bad++;
            $display("FAIL region[%0d] (%0d,%0d): got v=%0b rgb=%06h, want v=1 rgb=%06h",
                     i, qx[i], qy[i], vo, rgb, qe[i]);
         end
      end
   endtask

   task automatic test_pc();
      logic [23:0] rgb;
      logic vo;
      int qx[$];
      logic [23:0] qe[$];
      logic [49:0] b;
      b = '0;
      b = with_cell(b, 0, 0, 2'b01);
      b = with_cell(b, 0, 1, 2'b10);
      b = with_cell(b, 0, 2, 2'b11);
      pc_board_i = b;
      frame_pulse();
      reveal_pc_i = 1'b0;
      qx = '{320, 384, 446, 508};
      qe = '{24'h202020, 24'hFFFF00, 24'hFFA500, 24'h202020};
      for (int i = 0; i < qx.size(); i++) begin
         drive_px(qx[i], 10, 1'b1, rgb, vo);
         total++;
         if (vo !== 1'b1 || rgb !== qe[i]) begin
            bad++;
            $display("FAIL pc_hidden[%0d]: got rgb=%06h, want rgb=%06h", i, rgb, qe[i]);
         end
      end
      reveal_pc_i = 1'b1;
      qx = '{320, 508};
      qe = '{24'h800080, 24'h202020};
      for (int i = 0; i < qx.size(); i++) begin
         drive_px(qx[i], 10, 1'b1, rgb, vo);
         total++;
         if (vo !== 1'b1 || rgb !== qe[i]) begin
            bad++;
            $display("FAIL pc_reveal[%0d]: got rgb=%06h, want rgb=%06h", i, rgb, qe[i]);
         end
      end
      reveal_pc_i = 1'b0;
   endtask

   task automatic test_preview();
      logic [23:0] rgb;
      logic vo;
      int qx[$], qy[$];
      logic [23:0] qe[$];
      logic [49:0] b;
      b = '0;
      b = with_cell(b, 0, 0, 2'b01);
      b = with_cell(b, 2, 3, 2'b01);
      player_board_i = b;
      cursor_row_i = 3'd0;
      cursor_col_i = 3'd3;
      place_len_i = 3'd4;
      place_vert_i = 1'b0;
      place_active_i = 1'b1;
      frame_pulse();
      qx = '{196, 258, 10, 134, 196};
      qy = '{10, 10, 10, 10, 72};
      qe = '{24'hFF8C00, 24'hFF8C00, 24'h00FF00, 24'h0000FF, 24'h0000FF};
      for (int i = 0; i < qx.size(); i++) begin
         drive_px(qx[i], qy[i], 1'b1, rgb, vo);
         total++;
         if (vo !== 1'b1 || rgb !== qe[i]) begin
            bad++;
            $display("FAIL preview_h[%0d]: got rgb=%06h, want rgb=%06h", i, rgb, qe[i]);
         end
      end
      place_vert_i = 1'b1;
      frame_pulse();
      qx = '{196, 196, 196, 196, 196, 258};
      qy = '{10, 72, 134, 196, 258, 10};
      qe = '{24'hFF8C00, 24'hFF8C00, 24'hFF0000, 24'hFF8C00, 24'h0000FF, 24'h0000FF};
      for (int i = 0; i < qx.size(); i++) begin
         drive_px(qx[i], qy[i], 1'b1, rgb, vo);
         total++;
         if (vo !== 1'b1 || rgb !== qe[i]) begin
            bad++;
            $display("FAIL preview_v[%0d]: got rgb=%06h, want rgb=%06h", i, rgb, qe[i]);
         end
      end
      // length runs past the bottom edge: rows 3 and 4 only
      cursor_row_i = 3'd3;
      place_len_i = 3'd7;
      frame_pulse();
      qx = '{196, 196, 196};
      qy = '{196, 258, 134};
      qe = '{24'hFF8C00, 24'hFF8C00, 24'h00FF00};
      for (int i = 0; i < qx.size(); i++) begin
         drive_px(qx[i], qy[i], 1'b1, rgb, vo);
         total++;
         if (vo !== 1'b1 || rgb !== qe[i]) begin
            bad++;
            $display("FAIL preview_clip[%0d]: got rgb=%06h, want rgb=%06h", i, rgb, qe[i]);
         end
      end
      place_active_i = 1'b0;
      place_vert_i = 1'b0;
      place_len_i = 3'd0;
   endtask

   task automatic test_snapshot();
      logic [23:0] rgb;
      logic vo;
      player_board_i = with_cell(50'h0, 0, 0, 2'b01);
      cursor_row_i = 3'd4;
      cursor_col_i = 3'd4;
      frame_pulse();
      player_board_i = '1;
      cursor_row_i = 3'd0;
      cursor_col_i = 3'd0;
      place_active_i = 1'b1;
      place_len_i = 3'd5;
      drive_px(10, 10, 1'b1, rgb, vo);
      total++;
      if (rgb !== 24'h00FF00) begin
         bad++;
         $display("FAIL snapshot_hold_00: got rgb=%06h, want rgb=00ff00", rgb);
      end
      drive_px(72, 72, 1'b1, rgb, vo);
      total++;
      if (rgb !== 24'h0000FF) begin
         bad++;
         $display("FAIL snapshot_hold_11: got rgb=%06h, want rgb=0000ff", rgb);
      end
      cursor_row_i = 3'd4;
      cursor_col_i = 3'd4;
      place_active_i = 1'b0;
      frame_pulse();
      drive_px(10, 10, 1'b1, rgb, vo);
      total++;
      if (rgb !== 24'hFFFF00) begin
         bad++;
         $display("FAIL snapshot_update_00: got rgb=%06h, want rgb=ffff00", rgb);
      end
      drive_px(72, 72, 1'b1, rgb, vo);
      total++;
      if (rgb !== 24'hFFFF00) begin
         bad++;
         $display("FAIL snapshot_update_11: got rgb=%06h, want rgb=ffff00", rgb);
      end
   endtask

   task automatic test_blink();
      logic [23:0] rgb, exp;
      logic vo;
      player_board_i = '0;
      pc_board_i = '0;
      cursor_row_i = 3'd2;
      cursor_col_i = 3'd2;
      place_active_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         frame_pulse();
`ifdef CURSOR_BLINK_EN
         exp = (((n_pulses / 2) % 2) == 0) ? 24'hFFFFFF : 24'h0000FF;
`else
         exp = 24'hFFFFFF;
`endif
         drive_px(144, 144, 1'b1, rgb, vo);
         total++;
         if (rgb !== exp) begin
            bad++;
            $display("FAIL blink[%0d] pulses=%0d: got rgb=%06h, want rgb=%06h",
                     k, n_pulses, rgb, exp);
         end
      end
      drive_px(72, 144, 1'b1, rgb, vo);
      total++;
      if (rgb !== 24'h0000FF) begin
         bad++;
         $display("FAIL blink_neighbour: got rgb=%06h, want rgb=0000ff", rgb);
      end
   endtask

   task automatic test_back_to_back();
      int qx[$], qy[$];
      logic qv[$];
      logic [23:0] qe[$];
      logic [23:0] rgb;
      qx = '{10, 2, 310, 100, 330, 72};
      qy = '{10, 2, 5, 100, 10, 144};
      qv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      qe = '{24'h0000FF, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h202020, 24'h0000FF};
      for (int i = 0; i <= qx.size(); i++) begin
         if (i < qx.size()) begin
            x_i = 10'(qx[i]);
            y_i = 10'(qy[i]);
            pix_valid_i = qv[i];
         end else begin
            pix_valid_i = 1'b0;
         end
         @(posedge clk);
         #1;
         if (i >= 1) begin
            rgb = {r_o, g_o, b_o};
            $display("stream[%0d] -> v=%0b rgb=%06h", i - 1, pix_valid_o, rgb);
            total++;
            if (pix_valid_o !== qv[i-1] || rgb !== qe[i-1]) begin
               bad++;
               $display("FAIL stream[%0d]: got v=%0b rgb=%06h, want v=%0b rgb=%06h",
                        i - 1, pix_valid_o, rgb, qv[i-1], qe[i-1]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] rgb;
      logic vo;
      player_board_i = with_cell(50'h0, 0, 1, 2'b01);
      cursor_row_i = 3'd4;
      cursor_col_i = 3'd4;
      frame_pulse();
      x_i = 10'd72;
      y_i = 10'd10;
      pix_valid_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (pix_valid_o !== 1'b1 || {r_o, g_o, b_o} !== 24'h00FF00) begin
         bad++;
         $display("FAIL pre_reset: got v=%0b rgb=%06h, want v=1 rgb=00ff00",
                  pix_valid_o, {r_o, g_o, b_o});
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (pix_valid_o !== 1'b0 || {r_o, g_o, b_o} !== 24'h0) begin
         bad++;
         $display("FAIL async_reset: got v=%0b rgb=%06h, want v=0 rgb=000000",
                  pix_valid_o, {r_o, g_o, b_o});
      end
      pix_valid_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_pulses = 0;
      drive_px(72, 10, 1'b1, rgb, vo);
      total++;
      if (vo !== 1'b1 || rgb !== 24'h0000FF) begin
         bad++;
         $display("FAIL post_reset_agua: got v=%0b rgb=%06h, want v=1 rgb=0000ff", vo, rgb);
      end
      frame_pulse();
      drive_px(72, 10, 1'b1, rgb, vo);
      total++;
      if (vo !== 1'b1 || rgb !== 24'h00FF00) begin
         bad++;
         $display("FAIL post_reset_snapshot: got v=%0b rgb=%06h, want v=1 rgb=00ff00", vo, rgb);
      end
   endtask

   initial begin
      x_i = '0;
      y_i = '0;
      pix_valid_i = 1'b0;
      frame_start_i = 1'b0;
      player_board_i = '0;
      pc_board_i = '0;
      cursor_row_i = '0;
      cursor_col_i = '0;
      place_active_i = 1'b0;
      place_len_i = '0;
      place_vert_i = 1'b0;
      reveal_pc_i = 1'b0;
      test_reset();
      test_basic();
      test_regions();
      test_pc();
      test_preview();
      test_snapshot();
      test_blink();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
